// File: rtl/pipelined_main_memory.sv
// pipelined_main_memory
//   Single-port word memory with per-byte write enables, a fixed-latency read
//   pipeline and an optional zero-fill sequence after reset.
//
// Parameters
//   DATA_WIDTH     word width in bits (multiple of 8, 8..64)
//   ADDR_WIDTH     address width in bits
//   DEPTH          number of words (DEPTH <= 2**ADDR_WIDTH)
//   READ_LATENCY   cycles from read acceptance to OutValid (1..4)
//   CLEAR_ON_RESET 1: zero every word after reset, 0: contents retained
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   ReqValid     request present this cycle
//   ReqReady     block accepts a request this cycle
//   WriteEnable  1 = write, 0 = read
//   ByteEnable   per-byte write mask (ignored on reads)
//   Address      word address
//   Data         write data
//   OutData      read data, held between OutValid pulses
//   OutValid     one-cycle pulse marking returned read data
//   AddrError    one-cycle pulse, the cycle after an out-of-range request
module pipelined_main_memory #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned ADDR_WIDTH     = 13,
    parameter int unsigned DEPTH          = 8192,
    parameter int unsigned READ_LATENCY   = 2,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    ReqValid,
    output logic                    ReqReady,
    input  logic                    WriteEnable,
    input  logic [DATA_WIDTH/8-1:0] ByteEnable,
    input  logic [ADDR_WIDTH-1:0]   Address,
    input  logic [DATA_WIDTH-1:0]   Data,
    output logic [DATA_WIDTH-1:0]   OutData,
    output logic                    OutValid,
    output logic                    AddrError
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;
    // Without a clear sequence the FSM comes out of reset already serving requests.
    localparam logic [0:0] ST_RESET = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_READY;

    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);

    logic [0:0]            state_q, state_d;
    logic [IDX_W-1:0]      clr_q, clr_d;
    logic                  clr_we;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  accept;
    logic                  in_range;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [IDX_W-1:0]      idx;

    logic [READ_LATENCY-1:0] vld_q;
    logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];
    logic                    err_q;

    // ReqReady is gated by reset_n so a CLEAR_ON_RESET=0 build (reset state READY)
    // still reports not-ready while reset is held.
    assign ReqReady = reset_n & (state_q == ST_READY);
    assign accept   = ReqValid & ReqReady;
    assign in_range = {1'b0, Address} < DEPTH_EXT;
    assign idx      = Address[IDX_W-1:0];
    assign wr_acc   = accept & WriteEnable & in_range;
    assign rd_acc   = accept & ~WriteEnable;

    // Control FSM: INIT walks the clear counter over every word, READY serves requests.
    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        clr_we  = 1'b0;
        if (state_q == ST_INIT) begin
            clr_we = reset_n;
            clr_d  = clr_q + IDX_W'(1);
            if (clr_q == LAST_IDX) begin
                state_d = ST_READY;
                clr_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RESET;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
        end
    end

    // Storage is deliberately not reset so contents survive reset when clearing is off.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_q] <= '0;
        end else if (wr_acc) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (ByteEnable[b]) begin
                    mem[idx][8*b +: 8] <= Data[8*b +: 8];
                end
            end
        end
    end

    // Read pipeline. Stage 0 samples memory at the accept edge, so a write accepted
    // the cycle before is already visible. Data stages only load when a valid
    // entry moves in, which keeps OutData stable between pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            err_q    <= accept & ~in_range;
            vld_q[0] <= rd_acc;
            if (rd_acc) begin
                dat_q[0] <= in_range ? mem[idx] : '0;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign OutValid  = vld_q[READ_LATENCY-1];
    assign OutData   = dat_q[READ_LATENCY-1];
    assign AddrError = err_q;

endmodule
